// File: rtl/noc_pkg.sv
// Shared flit-level definitions for the NI transmit path: widths, markers, FSM states.
package noc_pkg;

  localparam int FLIT_W = 8;
  localparam int NODE_W = 2;

  localparam logic [5:0]        HEAD_MARK = 6'b101111;
  localparam logic [FLIT_W-1:0] TRAILER   = 8'hFF;

  typedef enum logic [2:0] {IDLE, HEAD, BODY, TRAIL, CSUM} tx_state_t;

  // Payload bytes that could be mistaken for a head or trailer flit on the wire.
  function automatic logic is_illegal_body(input logic [FLIT_W-1:0] b);
    return (b == TRAILER) || (b[7:2] == HEAD_MARK);
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous payload FIFO with first-word-fall-through read data and an occupancy count.
module ni_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr_s = wr && !full;
  assign do_rd_s = rd && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit packetizer: buffers payload, then emits head / body / trailer flits.
// Optional NI_CHECKSUM_EN inserts an XOR checksum flit before the trailer.
module ni_packetizer
  import noc_pkg::*;
#(
  parameter logic [NODE_W-1:0] NODE_ID    = 2'd0,
  parameter int                FIFO_DEPTH = 8,
  parameter int                MAX_BODY   = 8,
  parameter int                LEN_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] data_in,
  input  logic              data_wr,
  output logic              data_full,
  input  logic              core_req,
  input  logic [NODE_W-1:0] core_dest,
  input  logic [LEN_W-1:0]  core_len,
  output logic              core_ack,
  input  logic              noc_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic              busy,
  output logic              pkt_sent,
  output logic              err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state_q;
  logic [NODE_W-1:0] dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  remaining_d;
  logic [FLIT_W-1:0] flit_out_q;
  logic              flit_valid_q;
  logic              core_ack_q;
  logic              pkt_sent_q;
  logic              err_q;
`ifdef NI_CHECKSUM_EN
  logic [6:0]        csum_q;
`endif

  logic [FLIT_W-1:0] fifo_dout_s;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              xfer_s;
  logic              bad_byte_s;
  logic              req_bad_s;
  logic              req_ok_s;

  assign bad_byte_s  = data_wr && (fifo_full_s || is_illegal_body(data_in));
  assign push_s      = data_wr && !fifo_full_s && !is_illegal_body(data_in);
  assign xfer_s      = flit_valid_q && noc_ready;
  assign remaining_d = remaining_q - 1'b1;
  assign req_bad_s   = (core_dest == NODE_ID) || (int'(core_len) > MAX_BODY);
  assign req_ok_s    = int'(fifo_count_s) >= int'(core_len);
  // The byte being presented next is popped in the same edge that loads it into flit_out.
  assign pop_s = xfer_s && !fifo_empty_s &&
                 (((state_q == HEAD) && (len_q != '0)) ||
                  ((state_q == BODY) && (remaining_d != '0)));

  ni_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push_s),
    .rd    (pop_s),
    .din   (data_in),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Packet FSM with registered flit and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
      flit_out_q   <= 8'h00;
      flit_valid_q <= 1'b0;
      core_ack_q   <= 1'b0;
      pkt_sent_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef NI_CHECKSUM_EN
      csum_q       <= 7'd0;
`endif
    end else begin
      core_ack_q <= 1'b0;
      pkt_sent_q <= 1'b0;
      err_q      <= bad_byte_s;
      case (state_q)
        IDLE: begin
          // Skip the cycle right after an ack so a still-high request is not consumed twice.
          if (core_req && !core_ack_q) begin
            if (req_bad_s) begin
              core_ack_q <= 1'b1;
              err_q      <= 1'b1;
            end else if (req_ok_s) begin
              dest_q       <= core_dest;
              len_q        <= core_len;
              core_ack_q   <= 1'b1;
              flit_out_q   <= {HEAD_MARK, core_dest};
              flit_valid_q <= 1'b1;
              state_q      <= HEAD;
`ifdef NI_CHECKSUM_EN
              csum_q       <= 7'd0;
`endif
            end
          end
        end
        HEAD: begin
          if (xfer_s) begin
            if (len_q == '0) begin
`ifdef NI_CHECKSUM_EN
              flit_out_q <= {1'b0, csum_q};
              state_q    <= CSUM;
`else
              flit_out_q <= TRAILER;
              state_q    <= TRAIL;
`endif
            end else begin
              flit_out_q  <= fifo_dout_s;
              remaining_q <= len_q;
              state_q     <= BODY;
`ifdef NI_CHECKSUM_EN
              csum_q      <= csum_q ^ fifo_dout_s[6:0];
`endif
            end
          end
        end
        BODY: begin
          if (xfer_s) begin
            remaining_q <= remaining_d;
            if (remaining_d != '0) begin
              flit_out_q <= fifo_dout_s;
`ifdef NI_CHECKSUM_EN
              csum_q     <= csum_q ^ fifo_dout_s[6:0];
`endif
            end else begin
`ifdef NI_CHECKSUM_EN
              flit_out_q <= {1'b0, csum_q};
              state_q    <= CSUM;
`else
              flit_out_q <= TRAILER;
              state_q    <= TRAIL;
`endif
            end
          end
        end
        CSUM: begin
          if (xfer_s) begin
            flit_out_q <= TRAILER;
            state_q    <= TRAIL;
          end
        end
        TRAIL: begin
          if (xfer_s) begin
            flit_valid_q <= 1'b0;
            pkt_sent_q   <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          flit_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign data_full  = fifo_full_s;
  assign busy       = (state_q != IDLE);
  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign core_ack   = core_ack_q;
  assign pkt_sent   = pkt_sent_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed self-checking bench for ni_packetizer (honours NI_CHECKSUM_EN in its expectations).
module tb_ni_packetizer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_wr;
  logic       data_full;
  logic       core_req;
  logic [1:0] core_dest;
  logic [3:0] core_len;
  logic       core_ack;
  logic       noc_ready;
  logic [7:0] flit_out;
  logic       flit_valid;
  logic       busy;
  logic       pkt_sent;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] body_q[$];
  logic [7:0] exp_q[$];
  int cyc;

  ni_packetizer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_wr(data_wr), .data_full(data_full),
    .core_req(core_req), .core_dest(core_dest), .core_len(core_len), .core_ack(core_ack),
    .noc_ready(noc_ready), .flit_out(flit_out), .flit_valid(flit_valid), .busy(busy),
    .pkt_sent(pkt_sent), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic exp_err, input string tag);
    data_in = b;
    data_wr = 1'b1;
    tick();
    data_wr = 1'b0;
    check(tag, err, exp_err);
  endtask

  task automatic push_body();
    foreach (body_q[i]) push(body_q[i], 1'b0, "push_err");
  endtask

  // Model of the expected flit stream for the current body_q.
  task automatic build_exp(input logic [1:0] dest);
    logic [7:0] x;
    x = 8'h00;
    exp_q = {};
    exp_q.push_back({6'b101111, dest});
    foreach (body_q[i]) begin
      exp_q.push_back(body_q[i]);
      x = x ^ body_q[i];
    end
`ifdef NI_CHECKSUM_EN
    exp_q.push_back({1'b0, x[6:0]});
`endif
    exp_q.push_back(8'hFF);
  endtask

  task automatic wait_ack(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!core_ack && c < 50);
    core_req = 1'b0;
    check("ack_seen", core_ack, 1'b1);
  endtask

  task automatic request(input logic [1:0] dest);
    core_dest = dest;
    core_len  = 4'(body_q.size());
    core_req  = 1'b1;
  endtask

  task automatic collect(input bit toggle, input string tag);
    int idx;
    logic held;
    logic [7:0] held_flit;
    idx = 0;
    held = 1'b0;
    held_flit = 8'h00;
    for (int c = 0; c < 200 && idx < exp_q.size(); c++) begin
      if (held) check({tag, "_hold"}, flit_out, held_flit);
      noc_ready = toggle ? c[0] : 1'b1;
      held = 1'b0;
      check({tag, "_valid"}, flit_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      if (flit_valid && noc_ready) begin
        check({tag, "_flit"}, flit_out, exp_q[idx]);
        idx++;
      end else if (flit_valid) begin
        held = 1'b1;
        held_flit = flit_out;
      end
      tick();
    end
    noc_ready = 1'b1;
    check({tag, "_count"}, idx, exp_q.size());
    check({tag, "_sent"}, pkt_sent, 1'b1);
    check({tag, "_idle"}, flit_valid, 1'b0);
    check({tag, "_notbusy"}, busy, 1'b0);
  endtask

  task automatic reject(input logic [1:0] dest, input logic [3:0] len, input string tag);
    core_dest = dest;
    core_len  = len;
    core_req  = 1'b1;
    tick();
    core_req = 1'b0;
    check({tag, "_ack"}, core_ack, 1'b1);
    check({tag, "_err"}, err, 1'b1);
    check({tag, "_noflit"}, flit_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    tick();
    check({tag, "_ack_pulse"}, core_ack, 1'b0);
    check({tag, "_err_pulse"}, err, 1'b0);
    check({tag, "_noflit2"}, flit_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b0; data_in = 8'h00; data_wr = 1'b0; core_req = 1'b0;
    core_dest = 2'd0; core_len = 4'd0; noc_ready = 1'b1;
    repeat (2) tick();
    check("rst_flit", flit_out, 8'h00);
    check("rst_valid", flit_valid, 1'b0);
    check("rst_ack", core_ack, 1'b0);
    check("rst_sent", pkt_sent, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_full", data_full, 1'b0);
    rst = 1'b1;
    tick();

    // Basic send, ready tied high.
    body_q = '{8'h3A, 8'h55, 8'h01};
    push_body();
    request(2'd2);
    build_exp(2'd2);
    wait_ack(cyc);
    check("basic_latency", cyc, 1);
    check("basic_head_valid", flit_valid, 1'b1);
    collect(1'b0, "basic");

    // Same packet under alternating backpressure.
    push_body();
    request(2'd2);
    wait_ack(cyc);
    collect(1'b1, "bp");

    // Rejected requests and illegal bytes.
    reject(2'd0, 4'd1, "rej_self");
    reject(2'd2, 4'd9, "rej_len");
    push(8'hFF, 1'b1, "drop_ff");
    push(8'hBD, 1'b1, "drop_bd");
    core_dest = 2'd2; core_len = 4'd1; core_req = 1'b1;
    repeat (3) begin
      tick();
      check("empty_wait_ack", core_ack, 1'b0);
    end
    core_req = 1'b0;
    tick();

    // Zero-length packet.
    body_q = {};
    request(2'd2);
    build_exp(2'd2);
    wait_ack(cyc);
    collect(1'b0, "len0");

    // Fill the FIFO, overflow write, then drain with a maximum-length packet.
    body_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    push_body();
    check("full_after8", data_full, 1'b1);
    push(8'h18, 1'b1, "overflow_err");
    check("full_after9", data_full, 1'b1);
    request(2'd3);
    build_exp(2'd3);
    wait_ack(cyc);
    collect(1'b0, "max");
    check("full_drained", data_full, 1'b0);

    // Request waits until enough payload is buffered.
    body_q = '{8'h20, 8'h21, 8'h22, 8'h23};
    push(8'h20, 1'b0, "wait_push0");
    push(8'h21, 1'b0, "wait_push1");
    request(2'd1);
    repeat (3) begin
      tick();
      check("wait_noack", core_ack, 1'b0);
    end
    push(8'h22, 1'b0, "wait_push2");
    check("wait_noack3", core_ack, 1'b0);
    push(8'h23, 1'b0, "wait_push3");
    check("wait_noack4", core_ack, 1'b0);
    build_exp(2'd1);
    wait_ack(cyc);
    check("wait_latency", cyc, 1);
    collect(1'b0, "wait");

    // Reset while in BODY aborts the packet and flushes the FIFO.
    body_q = '{8'h44, 8'h45, 8'h46};
    push_body();
    request(2'd3);
    wait_ack(cyc);
    noc_ready = 1'b1;
    tick();
    check("mid_body0", flit_out, 8'h44);
    tick();
    check("mid_body1", flit_out, 8'h45);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_valid", flit_valid, 1'b0);
    check("mid_busy_rst", busy, 1'b0);
    check("mid_sent", pkt_sent, 1'b0);
    check("mid_flit", flit_out, 8'h00);
    body_q = '{8'h5A};
    request(2'd2);
    repeat (2) begin
      tick();
      check("mid_flushed", core_ack, 1'b0);
    end
    push(8'h5A, 1'b0, "mid_push");
    check("mid_noack", core_ack, 1'b0);
    build_exp(2'd2);
    wait_ack(cyc);
    check("mid_latency", cyc, 1);
    collect(1'b0, "post_rst");

    // Checksum pattern: 0F ^ F0 gives 7F when the checksum flit is built in.
    body_q = '{8'h0F, 8'hF0};
    push_body();
    request(2'd2);
    build_exp(2'd2);
    wait_ack(cyc);
    collect(1'b0, "csum");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Network-interface transmit side; the producer end of the NI-to-router flit path that the router's switch controller consumes.
- Buffers payload bytes from the local core and, on a send request, emits one packet into the router:
  - a head flit: HEAD marker plus destination node;
  - N body flits;
  - the trailer flit 8'hFF.
- Uses a valid/ready handshake against the router's noc_ready.

Parameters:
- NODE_ID, 2'd0, this node's address; requests addressed to it are rejected.
- FIFO_DEPTH, 8, payload buffer depth in bytes; power of two, minimum 2.
- MAX_BODY, 8, maximum body flits per packet; must be ≤ FIFO_DEPTH.
- LEN_W, 4, width of core_len; must hold MAX_BODY+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block.
- data_in  in  8  payload byte from the core.
- data_wr  in  1  push data_in into the payload FIFO.
- data_full  out  1  FIFO full, combinational from count.
- core_req  in  1  request to send a packet; level, held until core_ack.
- core_dest  in  2  destination node of the request.
- core_len  in  LEN_W  number of body flits, 0..MAX_BODY.
- core_ack  out  1  one-cycle pulse: request consumed, either accepted or rejected.
- noc_ready  in  1  router accepts a flit this cycle.
- flit_out  out  8  flit to the router.
- flit_valid  out  1  flit_out is valid.
- busy  out  1  a packet is in flight; high in every state other than IDLE.
- pkt_sent  out  1  one-cycle pulse after the trailer transfer.
- err  out  1  one-cycle pulse on any rejected request or dropped byte.

Behaviour:
- Reset: state IDLE, FIFO flushed (count 0), flit_out=8'h00, flit_valid=0, core_ack=0, pkt_sent=0, err=0, busy=0.
- Reset mid-packet: the packet is aborted with no trailer. flit_valid is low in the cycle after the reset edge.
- Transfer rule: a flit transfers at a rising edge where flit_valid && noc_ready.
  - While flit_valid=1 and noc_ready=0, flit_out holds stable.
  - flit_valid never drops without a transfer, except on reset.
- FIFO write rules:
  - data_wr pushes data_in when count<FIFO_DEPTH.
  - Illegal bytes are dropped with an err pulse. Illegal means 8'hFF, or data_in[7:2]==6'b101111.
  - data_wr while full is dropped with an err pulse, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle are allowed when not full; count is unchanged.
- States: IDLE, HEAD, BODY, TRAIL.
- IDLE:
  - If core_req=1 and core_dest==NODE_ID, or core_len>MAX_BODY: core_ack=1 and err=1 for one cycle; stay in IDLE.
  - Otherwise, if core_req=1 and count≥core_len: latch dest and len, core_ack=1, go to HEAD.
    - flit_out={6'b101111, dest} and flit_valid=1 from the next cycle.
    - Head latency: 1 cycle from the request being sampled.
  - Otherwise, if core_req=1 and count<core_len: wait in IDLE; no ack.
- HEAD, on transfer:
  - len==0: go to TRAIL.
  - Otherwise: go to BODY, flit_out = FIFO head byte, pop it, remaining=len.
- BODY, on transfer:
  - Decrement remaining.
  - If the decremented value is nonzero, present and pop the next byte; else go to TRAIL with flit_out=8'hFF.
- TRAIL, on transfer: go to IDLE, flit_valid=0, pkt_sent=1.
- Throughput: with noc_ready tied high, one packet takes len+2 flit cycles plus 1 IDLE cycle. The next core_ack can come at the earliest one cycle after pkt_sent.
- Byte order: body flits are sent in FIFO (write) order. No bubbles within a packet, because all payload is buffered before the head.

Optional Feature:
- Macro: NI_CHECKSUM_EN.
- Defined:
  - A checksum flit is inserted between the last body flit and the trailer: {1'b0, xor_of_body[6:0]}.
  - The checksum resets at each head.
  - For len==0 the checksum flit is 8'h00.
  - Packet length is len+3 flits.
  - The extra state is CSUM, entered from BODY, or from HEAD when len==0.
- Undefined: no CSUM state; packets carry exactly len+2 flits.

Decomposition:
- Package noc_pkg:
  - FLIT_W=8, NODE_W=2;
  - HEAD_MARK=6'b101111, TRAILER=8'hFF;
  - state enum tx_state_t {IDLE, HEAD, BODY, TRAIL, CSUM};
  - function is_illegal_body(byte).
- Sub-module ni_fifo: synchronous, parameterised by depth and width; ports wr, rd, din, dout, count, full, empty.
- The FSM and checksum stay in ni_packetizer.

Test Plan:
- Reset and basic send:
  - Stimulus: push 3A,55,01; core_req dest=2 len=3; noc_ready=1 (NODE_ID=0).
  - Required: flits BE,3A,55,01,FF on consecutive cycles; core_ack 1 cycle after the request; pkt_sent after FF.
- Backpressure:
  - Stimulus: same packet; noc_ready toggles 0/1 every cycle.
  - Required: each flit held stable while noc_ready=0; no duplicates or losses; 5 transfers total.
- Rejects and illegal bytes:
  - Stimulus: dest=0 (self), then len=9, then push FF and BD.
  - Required: each produces err=1; the two requests each get core_ack with no flits emitted; count unchanged.
- Boundaries:
  - Stimulus: len=0 request; then FIFO filled to 8 with a 9th write.
  - Required: len=0 gives BE then FF (dest 2). The 9th write is dropped with err=1 and data_full=1.
  - Stimulus: request len=4 with only 2 bytes buffered.
  - Required: waits with no core_ack until the 4th byte is pushed.
- Mid-packet reset:
  - Stimulus: rst=0 while in BODY.
  - Required: flit_valid=0 next cycle; no trailer; FIFO empty; a new packet after reset starts with a clean head.
- Checksum (NI_CHECKSUM_EN defined):
  - Stimulus: body 0F,F0.
  - Required: flits ..,0F,F0,7F,FF.
